pipe_reg_skid: RTL and testbench

Parametrised pipeline-stage register for the five-stage CPU, the general replacement for the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a DATA_W-bit payload and a CTRL_W-bit control bundle between two stages using a valid/ready handshake. A two-entry skid buffer gives full throughput with a registered upstream ready. It adds flush (bubble insertion), control gating on bubbles and an occupancy count, none of which the fixed latches provide.

---
 rtl/pipe_reg_skid.sv | 153 +++++++++++++++
 tb/tb_pipe_reg_skid.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_skid.sv
// rtl/pipe_reg_skid.sv - pipeline-stage register with two-entry skid buffer, flush and control gating
//
// Purpose: carries a DATA_W payload and a CTRL_W control bundle between two CPU
// pipeline stages over a valid/ready handshake at full throughput. The upstream
// ready depends only on registered state (plus start_i), never on out_ready_i.
//
// Ports:
//   clk_i        in   1       clock, rising edge
//   rst_i        in   1       asynchronous active-high reset
//   start_i      in   1       run enable; 0 freezes all state and blocks transfers
//   flush_i      in   1       synchronous flush; drops held and incoming entries
//   in_valid_i   in   1       upstream entry valid
//   in_data_i    in   DATA_W  upstream payload
//   in_ctrl_i    in   CTRL_W  upstream control bits
//   in_ready_o   out  1       block can accept an entry
//   out_valid_o  out  1       downstream entry valid
//   out_data_o   out  DATA_W  downstream payload
//   out_ctrl_o   out  CTRL_W  downstream control bits (zeroed on bubbles if CTRL_GATE)
//   out_ready_i  in   1       downstream can take an entry
//   count_o      out  2       entries held (0..2)

module pipe_reg_skid #(
    parameter int DATA_W    = 64,
    parameter int CTRL_W    = 2,
    parameter bit CTRL_GATE = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    input  logic              out_ready_i,
    output logic [1:0]        count_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

    logic acc;
    logic take;
    logic run;

    // Handshake outputs come from registered state only; start_i gates both
    // sides so a frozen block cannot complete a transfer.
    assign in_ready_o  = start_i & (state_q != TWO);
    assign out_valid_o = start_i & (state_q != EMPTY);
    assign acc         = in_valid_i & in_ready_o;
    assign take        = out_valid_o & out_ready_i;
    assign run         = start_i & ~flush_i;

    // State register and storage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

    // Next-state logic. Flush wins over every transition but only while running.
    always_comb begin
        state_d = state_q;
        if (start_i) begin
            if (flush_i) begin
                state_d = EMPTY;
            end else begin
                case (state_q)
                    EMPTY: if (acc) state_d = ONE;
                    ONE: begin
                        if (acc && !take)      state_d = TWO;
                        else if (!acc && take) state_d = EMPTY;
                    end
                    TWO:     if (take) state_d = ONE;
                    default: state_d = EMPTY;
                endcase
            end
        end
    end

    // Datapath loads. Flush leaves the data registers untouched; only state is
    // cleared, so stale payload stays visible behind out_valid_o=0.
    always_comb begin
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (run) begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        main_data_d = in_data_i;
                        main_ctrl_d = in_ctrl_i;
                    end
                end
                ONE: begin
                    if (acc && take) begin
                        main_data_d = in_data_i;
                        main_ctrl_d = in_ctrl_i;
                    end else if (acc) begin
                        // Downstream stalled with an entry in flight: park it in skid.
                        skid_data_d = in_data_i;
                        skid_ctrl_d = in_ctrl_i;
                    end
                end
                TWO: begin
                    if (take) begin
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output logic.
    always_comb begin
        out_data_o = main_data_q;
        out_ctrl_o = main_ctrl_q;
        if (CTRL_GATE && !out_valid_o) begin
            out_ctrl_o = '0;
        end
        case (state_q)
            ONE:     count_o = 2'd1;
            TWO:     count_o = 2'd2;
            default: count_o = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_pipe_reg_skid.sv
// tb/tb_pipe_reg_skid.sv - self-checking bench for pipe_reg_skid

module tb_pipe_reg_skid;

    logic        clk;
    logic        rst;
    logic        start;
    logic        flush;
    logic        in_valid;
    logic [63:0] in_data;
    logic [1:0]  in_ctrl;
    logic        out_ready;

    logic        in_ready_g, out_valid_g;
    logic [63:0] out_data_g;
    logic [1:0]  out_ctrl_g, count_g;
    logic        in_ready_n, out_valid_n;
    logic [63:0] out_data_n;
    logic [1:0]  out_ctrl_n, count_n;

    int total = 0;
    int bad   = 0;

    pipe_reg_skid #(.DATA_W(64), .CTRL_W(2), .CTRL_GATE(1'b1)) dut_g (
        .clk_i(clk), .rst_i(rst), .start_i(start), .flush_i(flush),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_ctrl_i(in_ctrl),
        .in_ready_o(in_ready_g), .out_valid_o(out_valid_g),
        .out_data_o(out_data_g), .out_ctrl_o(out_ctrl_g),
        .out_ready_i(out_ready), .count_o(count_g)
    );

    pipe_reg_skid #(.DATA_W(64), .CTRL_W(2), .CTRL_GATE(1'b0)) dut_n (
        .clk_i(clk), .rst_i(rst), .start_i(start), .flush_i(flush),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_ctrl_i(in_ctrl),
        .in_ready_o(in_ready_n), .out_valid_o(out_valid_n),
        .out_data_o(out_data_n), .out_ctrl_o(out_ctrl_n),
        .out_ready_i(out_ready), .count_o(count_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       tag;
        logic        st;
        logic        fl;
        logic        iv;
        logic [63:0] id;
        logic [1:0]  ic;
        logic        ordy;
        logic        ev;
        logic [63:0] ed;
        logic [1:0]  ec;
        logic [1:0]  ecn;
        logic        er;
        logic [1:0]  ecnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string tag, logic st, logic fl, logic iv, logic [63:0] id,
                                logic [1:0] ic, logic ordy, logic ev, logic [63:0] ed,
                                logic [1:0] ec, logic [1:0] ecn, logic er, logic [1:0] ecnt);
        vec_t v;
        v.tag = tag; v.st = st; v.fl = fl; v.iv = iv; v.id = id; v.ic = ic; v.ordy = ordy;
        v.ev = ev; v.ed = ed; v.ec = ec; v.ecn = ecn; v.er = er; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(string name, int idx, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic check_outputs(string tag, int idx, logic ev, logic [63:0] ed, logic [1:0] ec,
                                 logic [1:0] ecn, logic er, logic [1:0] ecnt);
        chk({tag, ".out_valid"}, idx, 64'(out_valid_g), 64'(ev));
        chk({tag, ".out_data"},  idx, out_data_g, ed);
        chk({tag, ".out_ctrl_gated"}, idx, 64'(out_ctrl_g), 64'(ec));
        chk({tag, ".out_ctrl_ungated"}, idx, 64'(out_ctrl_n), 64'(ecn));
        chk({tag, ".in_ready"},  idx, 64'(in_ready_g), 64'(er));
        chk({tag, ".count"},     idx, 64'(count_g), 64'(ecnt));
    endtask

    initial begin
        //              tag      st fl iv data   ic   ordy | ev data   ec   ecn  er cnt
        // streaming 1..4, one-cycle latency, count stays 1
        tbl.push_back(mk("stream", 1, 0, 1, 64'h1, 2'b11, 1, 0, 64'h0, 2'b00, 2'b00, 1, 2'd0));
        tbl.push_back(mk("stream", 1, 0, 1, 64'h2, 2'b11, 1, 1, 64'h1, 2'b11, 2'b11, 1, 2'd1));
        tbl.push_back(mk("stream", 1, 0, 1, 64'h3, 2'b11, 1, 1, 64'h2, 2'b11, 2'b11, 1, 2'd1));
        tbl.push_back(mk("stream", 1, 0, 1, 64'h4, 2'b11, 1, 1, 64'h3, 2'b11, 2'b11, 1, 2'd1));
        tbl.push_back(mk("stream", 1, 0, 0, 64'h0, 2'b00, 1, 1, 64'h4, 2'b11, 2'b11, 1, 2'd1));
        // empty with main_ctrl=11: gated reads 00, ungated reads 11
        tbl.push_back(mk("gate",   1, 0, 0, 64'h0, 2'b00, 1, 0, 64'h4, 2'b00, 2'b11, 1, 2'd0));
        // backpressure: A, B back-to-back, out_ready drops while A is output; C waits upstream
        tbl.push_back(mk("skid",   1, 0, 1, 64'hA, 2'b01, 1, 0, 64'h4, 2'b00, 2'b11, 1, 2'd0));
        tbl.push_back(mk("skid",   1, 0, 1, 64'hB, 2'b10, 0, 1, 64'hA, 2'b01, 2'b01, 1, 2'd1));
        tbl.push_back(mk("skid",   1, 0, 1, 64'hC, 2'b11, 0, 1, 64'hA, 2'b01, 2'b01, 0, 2'd2));
        tbl.push_back(mk("skid",   1, 0, 1, 64'hC, 2'b11, 1, 1, 64'hA, 2'b01, 2'b01, 0, 2'd2));
        tbl.push_back(mk("skid",   1, 0, 1, 64'hC, 2'b11, 1, 1, 64'hB, 2'b10, 2'b10, 1, 2'd1));
        tbl.push_back(mk("skid",   1, 0, 0, 64'h0, 2'b00, 1, 1, 64'hC, 2'b11, 2'b11, 1, 2'd1));
        tbl.push_back(mk("skid",   1, 0, 0, 64'h0, 2'b00, 1, 0, 64'hC, 2'b00, 2'b11, 1, 2'd0));
        // flush from TWO (5,6) with 7 incoming; 7 must never load
        tbl.push_back(mk("flush",  1, 0, 1, 64'h5, 2'b11, 0, 0, 64'hC, 2'b00, 2'b11, 1, 2'd0));
        tbl.push_back(mk("flush",  1, 0, 1, 64'h6, 2'b11, 0, 1, 64'h5, 2'b11, 2'b11, 1, 2'd1));
        tbl.push_back(mk("flush",  1, 1, 1, 64'h7, 2'b01, 0, 1, 64'h5, 2'b11, 2'b11, 0, 2'd2));
        tbl.push_back(mk("flush",  1, 0, 0, 64'h0, 2'b00, 1, 0, 64'h5, 2'b00, 2'b11, 1, 2'd0));
        tbl.push_back(mk("flush",  1, 0, 0, 64'h0, 2'b00, 1, 0, 64'h5, 2'b00, 2'b11, 1, 2'd0));
        // freeze holding 9 while in_valid and flush toggle
        tbl.push_back(mk("freeze", 1, 0, 1, 64'h9, 2'b10, 0, 0, 64'h5, 2'b00, 2'b11, 1, 2'd0));
        tbl.push_back(mk("freeze", 0, 1, 1, 64'hE, 2'b01, 1, 0, 64'h9, 2'b00, 2'b10, 0, 2'd1));
        tbl.push_back(mk("freeze", 0, 0, 0, 64'hE, 2'b01, 1, 0, 64'h9, 2'b00, 2'b10, 0, 2'd1));
        tbl.push_back(mk("freeze", 0, 1, 1, 64'hE, 2'b01, 1, 0, 64'h9, 2'b00, 2'b10, 0, 2'd1));
        tbl.push_back(mk("freeze", 1, 0, 0, 64'h0, 2'b00, 0, 1, 64'h9, 2'b10, 2'b10, 1, 2'd1));
        tbl.push_back(mk("freeze", 1, 0, 0, 64'h0, 2'b00, 1, 1, 64'h9, 2'b10, 2'b10, 1, 2'd1));
        tbl.push_back(mk("freeze", 1, 0, 0, 64'h0, 2'b00, 1, 0, 64'h9, 2'b00, 2'b10, 1, 2'd0));

        rst = 1'b0; start = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_data = '0; in_ctrl = '0; out_ready = 1'b0;

        // Reset pulse mid-cycle, before any clock edge: outputs settle asynchronously.
        #3 rst = 1'b1;
        #1;
        check_outputs("reset", 0, 1'b0, 64'h0, 2'b00, 2'b00, 1'b1, 2'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            start = tbl[i].st; flush = tbl[i].fl; in_valid = tbl[i].iv;
            in_data = tbl[i].id; in_ctrl = tbl[i].ic; out_ready = tbl[i].ordy;
            #1;
            check_outputs(tbl[i].tag, i, tbl[i].ev, tbl[i].ed, tbl[i].ec, tbl[i].ecn,
                          tbl[i].er, tbl[i].ecnt);
        end

        // Reset asserted mid-stream with an entry held: lost without a clock edge.
        @(negedge clk);
        start = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 64'h33; in_ctrl = 2'b01;
        out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        #1;
        check_outputs("load33", 0, 1'b1, 64'h33, 2'b01, 2'b01, 1'b1, 2'd1);
        rst = 1'b1;
        #1;
        check_outputs("midreset", 0, 1'b0, 64'h0, 2'b00, 2'b00, 1'b1, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_outputs("postreset", 0, 1'b0, 64'h0, 2'b00, 2'b00, 1'b1, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
